projectile_pool: RTL

- Consumer end of the ship firing interface: accepts the 1-cycle `projectile` fire pulse from the shooting controller and spawns a bullet at the ship's nose.
- Holds a fixed pool of bullet slots. Moves every live bullet upward once per frame tick, and retires bullets on top-of-screen exit or on a collision report.
- Publishes slot state to the renderer and to the collision checker.

---
 rtl/projectile_pool_if.sv | 31 +++
 rtl/projectile_pool.sv | 133 +++++++++++++
 2 files changed

// File: rtl/projectile_pool_if.sv
// Ship-firing / collision / render bundle between the shooter side and the
// projectile pool.
interface projectile_pool_if #(
    parameter int unsigned N_SLOTS = 4,
    parameter int unsigned X_W     = 10,
    parameter int unsigned Y_W     = 10
);
    localparam int unsigned IDX_W = $clog2(N_SLOTS);

    logic                   projectile;
    logic [X_W-1:0]         ship_x;
    logic [Y_W-1:0]         ship_y;
    logic                   frame_tick;
    logic                   hit_valid;
    logic [IDX_W-1:0]       hit_idx;
    logic [N_SLOTS-1:0]     active;
    logic [N_SLOTS*X_W-1:0] pos_x;
    logic [N_SLOTS*Y_W-1:0] pos_y;
    logic [IDX_W:0]         live_count;
    logic                   fire_dropped;

    modport master (
        output projectile, ship_x, ship_y, frame_tick, hit_valid, hit_idx,
        input  active, pos_x, pos_y, live_count, fire_dropped
    );

    modport slave (
        input  projectile, ship_x, ship_y, frame_tick, hit_valid, hit_idx,
        output active, pos_x, pos_y, live_count, fire_dropped
    );
endinterface

// File: rtl/projectile_pool.sv
// Fixed pool of bullet slots: spawn at ship nose, move up per frame, retire.
// Optional fire cooldown enabled by defining PROJ_COOLDOWN_EN.
module projectile_pool #(
    parameter int unsigned N_SLOTS  = 4,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 10,
    parameter int unsigned SPEED    = 4,
    parameter int unsigned NOSE_OFS = 8,
    parameter int unsigned COOLDOWN = 6
) (
    input logic              clk,
    input logic              reset,
    projectile_pool_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(N_SLOTS);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [Y_W-1:0] SPEED_Y = Y_W'(SPEED);
    localparam logic [Y_W-1:0] NOSE_Y  = Y_W'(NOSE_OFS);

    logic [N_SLOTS-1:0] active_q, active_d;
    logic [X_W-1:0]     x_q [N_SLOTS];
    logic [X_W-1:0]     x_d [N_SLOTS];
    logic [Y_W-1:0]     y_q [N_SLOTS];
    logic [Y_W-1:0]     y_d [N_SLOTS];
    logic [CNT_W-1:0]   count_q, count_d;
    logic               drop_q, drop_d;

    logic               any_free;
    logic [IDX_W-1:0]   spawn_idx;
    logic               spawn_ok;
    logic [Y_W-1:0]     spawn_y;
    logic               cd_busy;

`ifdef PROJ_COOLDOWN_EN
    localparam int unsigned CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
    logic [CD_W-1:0] cd_q, cd_d;

    assign cd_busy = (cd_q != '0);

    always_comb begin
        cd_d = cd_q;
        if (spawn_ok) begin
            cd_d = CD_W'(COOLDOWN);
        end else if (bus.frame_tick && cd_busy) begin
            cd_d = cd_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cd_q <= '0;
        end else begin
            cd_q <= cd_d;
        end
    end
`else
    logic unused_cooldown;
    assign unused_cooldown = (COOLDOWN != 0);
    assign cd_busy = 1'b0;
`endif

    // Lowest-index free slot, judged on the registered state only
    always_comb begin
        any_free  = 1'b0;
        spawn_idx = '0;
        for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                any_free  = 1'b1;
                spawn_idx = IDX_W'(i);
            end
        end
    end

    assign spawn_ok = bus.projectile && any_free && !cd_busy;
    assign spawn_y  = (bus.ship_y < NOSE_Y) ? '0 : bus.ship_y - NOSE_Y;
    assign drop_d   = bus.projectile && !spawn_ok;

    always_comb begin
        active_d = active_q;
        count_d  = '0;
        for (int i = 0; i < int'(N_SLOTS); i++) begin
            x_d[i] = x_q[i];
            y_d[i] = y_q[i];
            if (active_q[i]) begin
                if (bus.hit_valid && bus.hit_idx == IDX_W'(i)) begin
                    active_d[i] = 1'b0;
                end else if (bus.frame_tick) begin
                    if (y_q[i] >= SPEED_Y) begin
                        y_d[i] = y_q[i] - SPEED_Y;
                    end else begin
                        active_d[i] = 1'b0;
                    end
                end
            end else if (spawn_ok && spawn_idx == IDX_W'(i)) begin
                active_d[i] = 1'b1;
                x_d[i]      = bus.ship_x;
                y_d[i]      = spawn_y;
            end
        end
        for (int i = 0; i < int'(N_SLOTS); i++) begin
            count_d = count_d + {{(CNT_W-1){1'b0}}, active_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            active_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
            for (int i = 0; i < int'(N_SLOTS); i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            active_q <= active_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            for (int i = 0; i < int'(N_SLOTS); i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    assign bus.active       = active_q;
    assign bus.live_count   = count_q;
    assign bus.fire_dropped = drop_q;

    for (genvar g = 0; g < int'(N_SLOTS); g++) begin : g_pack
        assign bus.pos_x[g*X_W +: X_W] = x_q[g];
        assign bus.pos_y[g*Y_W +: Y_W] = y_q[g];
    end
endmodule
